// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and default sizes for the multi-port register file
//    clr_state_t       : bulk-clear engine states (IDLE, CLEAR, DONE)
//    REGFILE_XLEN_DEF  : default register width
//    REGFILE_NREGS_DEF : default register count
package regfile_pkg;
   typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_t;
   localparam int REGFILE_XLEN_DEF  = 32;
   localparam int REGFILE_NREGS_DEF = 32;
endpackage

// File: rtl/regfile_clear_fsm.sv
// regfile_clear_fsm: sequenced bulk-clear engine, one register per cycle from r1 upward
//    clk, rst (sync, active-low)
//    clr_req   in  : start a clear (accepted in IDLE or DONE)
//    clr_wr_en out : zero reg[clr_ptr] this cycle
//    clr_ptr   out : register being cleared
//    clr_busy  out : clear in progress
//    clr_done  out : one-cycle completion pulse
module regfile_clear_fsm
   import regfile_pkg::*;
#(
   parameter int NREGS = REGFILE_NREGS_DEF,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_req,
   output logic          clr_wr_en,
   output logic [AW-1:0] clr_ptr,
   output logic          clr_busy,
   output logic          clr_done
);
   clr_state_t    state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE:    if (clr_req) begin
                     state_d = CLEAR;
                     ptr_d   = AW'(1);
                  end
         CLEAR:   begin
                     ptr_d   = ptr_q + 1'b1;
                     state_d = (ptr_q == AW'(NREGS - 1)) ? DONE : CLEAR;
                  end
         // a request arriving during DONE starts the next clear immediately
         DONE:    begin
                     state_d = clr_req ? CLEAR : IDLE;
                     ptr_d   = AW'(1);
                  end
         default: begin
                     state_d = IDLE;
                     ptr_d   = AW'(1);
                  end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         ptr_q   <= AW'(1);
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   assign clr_busy  = (state_q == CLEAR);
   assign clr_wr_en = clr_busy;
   assign clr_ptr   = ptr_q;
   assign clr_done  = (state_q == DONE);
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: two-write, NRD-read register file with r0 hardwired to zero and bulk clear
//    clk, rst (sync, active-low)
//    we_a/wa_a/wd_a    : write port A
//    we_b/wa_b/wd_b    : write port B, wins on same-address collision
//    ra / rd           : packed read addresses / data, port i at [i*AW] / [i*XLEN]
//    clr_req, clr_busy, clr_done : bulk-clear handshake
//    wr_conflict       : registered pulse after both ports wrote the same nonzero address
//    Optional macro REGFILE_BYPASS_EN: same-cycle write-to-read forwarding
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int XLEN  = REGFILE_XLEN_DEF,
   parameter int NREGS = REGFILE_NREGS_DEF,
   parameter int NRD   = 2,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_a,
   input  logic [AW-1:0]     wa_a,
   input  logic [XLEN-1:0]   wd_a,
   input  logic              we_b,
   input  logic [AW-1:0]     wa_b,
   input  logic [XLEN-1:0]   wd_b,
   input  logic [NRD*AW-1:0] ra,
   output logic [NRD*XLEN-1:0] rd,
   input  logic              clr_req,
   output logic              clr_busy,
   output logic              clr_done,
   output logic              wr_conflict
);
   logic [XLEN-1:0] regs_q [NREGS];
   logic [XLEN-1:0] regs_d [NREGS];
   logic            wr_conflict_q, wr_conflict_d;
   logic            clr_wr_en;
   logic [AW-1:0]   clr_ptr;
   logic            wr_a_ok, wr_b_ok;

   regfile_clear_fsm #(.NREGS(NREGS), .AW(AW)) u_clr (
      .clk       (clk),
      .rst       (rst),
      .clr_req   (clr_req),
      .clr_wr_en (clr_wr_en),
      .clr_ptr   (clr_ptr),
      .clr_busy  (clr_busy),
      .clr_done  (clr_done)
   );

   assign wr_a_ok = we_a && (wa_a != '0) && !clr_busy;
   assign wr_b_ok = we_b && (wa_b != '0) && !clr_busy;

   // port B is applied last so it overwrites port A on a collision
   always_comb begin
      regs_d = regs_q;
      if (clr_wr_en) regs_d[clr_ptr] = '0;
      if (wr_a_ok) regs_d[wa_a] = wd_a;
      if (wr_b_ok) regs_d[wa_b] = wd_b;
      regs_d[0] = '0;
      wr_conflict_d = wr_a_ok && wr_b_ok && (wa_a == wa_b);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         regs_q        <= '{default: '0};
         wr_conflict_q <= 1'b0;
      end else begin
         regs_q        <= regs_d;
         wr_conflict_q <= wr_conflict_d;
      end
   end

   assign wr_conflict = wr_conflict_q;

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0] a;
      assign a = ra[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
      // accepted writes never target r0, so a match implies a nonzero address
      assign rd[i*XLEN +: XLEN] = (wr_b_ok && wa_b == a) ? wd_b :
                                  (wr_a_ok && wa_a == a) ? wd_a :
                                  (a == '0) ? '0 : regs_q[a];
`else
      assign rd[i*XLEN +: XLEN] = (a == '0) ? '0 : regs_q[a];
`endif
   end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed self-checking bench for regfile_mp (default sizes)
module tb_regfile_mp;
   logic        clk = 1'b0;
   logic        rst;
   logic        we_a, we_b;
   logic [4:0]  wa_a, wa_b;
   logic [31:0] wd_a, wd_b;
   logic [9:0]  ra;
   logic [63:0] rd;
   logic        clr_req, clr_busy, clr_done, wr_conflict;
   int          n_vec = 0;
   int          n_err = 0;

   regfile_mp dut (
      .clk         (clk),
      .rst         (rst),
      .we_a        (we_a),
      .wa_a        (wa_a),
      .wd_a        (wd_a),
      .we_b        (we_b),
      .wa_b        (wa_b),
      .wd_b        (wd_b),
      .ra          (ra),
      .rd          (rd),
      .clr_req     (clr_req),
      .clr_busy    (clr_busy),
      .clr_done    (clr_done),
      .wr_conflict (wr_conflict)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd_at(input logic [4:0] a0, input logic [4:0] a1);
      ra = {a1, a0};
      #1;
   endtask

   initial begin
      rst = 1'b0; we_a = 0; we_b = 0; wa_a = 0; wa_b = 0; wd_a = 0; wd_b = 0;
      ra = 0; clr_req = 0;
      tick(); tick();
      rst = 1'b1;
      for (int a = 0; a < 32; a++) begin
         rd_at(5'(a), 5'(31 - a));
         chk("reset_rd0", rd[31:0], 32'h0);
         chk("reset_rd1", rd[63:32], 32'h0);
      end
      chk("reset_busy", {31'b0, clr_busy}, 32'h0);
      chk("reset_done", {31'b0, clr_done}, 32'h0);
      chk("reset_conflict", {31'b0, wr_conflict}, 32'h0);

      we_a = 1; wa_a = 5; wd_a = 32'hDEADBEEF;
      we_b = 1; wa_b = 9; wd_b = 32'h12345678;
      tick();
      we_a = 0; we_b = 0;
      rd_at(5, 9);
      chk("wr_a_r5", rd[31:0], 32'hDEADBEEF);
      chk("wr_b_r9", rd[63:32], 32'h12345678);
      chk("no_conflict_diff", {31'b0, wr_conflict}, 32'h0);
      we_a = 1; wa_a = 0; wd_a = 32'hFFFFFFFF;
      tick();
      we_a = 0;
      rd_at(0, 0);
      chk("r0_zero", rd[31:0], 32'h0);

      we_a = 1; wa_a = 7; wd_a = 32'h1;
      we_b = 1; wa_b = 7; wd_b = 32'h2;
      tick();
      we_a = 0; we_b = 0;
      rd_at(7, 5);
      chk("collide_r7", rd[31:0], 32'h2);
      chk("conflict_pulse", {31'b0, wr_conflict}, 32'h1);
      tick();
      chk("conflict_one_cycle", {31'b0, wr_conflict}, 32'h0);

      rd_at(3, 7);
      we_a = 1; wa_a = 3; wd_a = 32'h55;
      we_b = 1; wa_b = 7; wd_b = 32'h22;
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("bypass_r3", rd[31:0], 32'h55);
      chk("bypass_r7_b", rd[63:32], 32'h22);
`else
      chk("nobypass_r3_old", rd[31:0], 32'h0);
      chk("nobypass_r7_old", rd[63:32], 32'h2);
`endif
      tick();
      we_a = 0; we_b = 0;
      #1;
      chk("r3_after", rd[31:0], 32'h55);
      chk("r7_after", rd[63:32], 32'h22);

      for (int a = 1; a < 32; a++) begin
         we_a = 1; wa_a = 5'(a); wd_a = 32'h100 + a;
         tick();
      end
      we_a = 0;
      rd_at(31, 1);
      chk("fill_r31", rd[31:0], 32'h11F);
      chk("fill_r1", rd[63:32], 32'h101);

      clr_req = 1;
      tick();
      clr_req = 0;
      for (int c = 0; c < 31; c++) begin
         chk("clr_busy_hi", {31'b0, clr_busy}, 32'h1);
         chk("clr_done_lo", {31'b0, clr_done}, 32'h0);
         if (c == 3) begin
            rd_at(3, 4);
            chk("mid_clr_r3", rd[31:0], 32'h0);
            chk("mid_clr_r4", rd[63:32], 32'h104);
         end
         if (c == 10) begin we_a = 1; wa_a = 2; wd_a = 32'hBAD; end
         if (c == 11) begin
            we_a = 0;
            rd_at(2, 2);
            chk("clr_drop_wr", rd[31:0], 32'h0);
         end
         clr_req = (c == 12);
         tick();
      end
      clr_req = 0; we_a = 0;
      chk("clr_busy_end", {31'b0, clr_busy}, 32'h0);
      chk("clr_done_pulse", {31'b0, clr_done}, 32'h1);
      tick();
      chk("clr_done_once", {31'b0, clr_done}, 32'h0);
      chk("clr_busy_idle", {31'b0, clr_busy}, 32'h0);
      for (int a = 0; a < 32; a++) begin
         rd_at(5'(a), 5'(a));
         chk("clr_all_zero", rd[31:0], 32'h0);
      end

      we_a = 1; wa_a = 20; wd_a = 32'hA5A5A5A5;
      tick();
      we_a = 0;
      rd_at(20, 20);
      chk("r20_set", rd[31:0], 32'hA5A5A5A5);
      clr_req = 1;
      tick();
      clr_req = 0;
      for (int c = 0; c < 9; c++) tick();
      rst = 0;
      we_b = 1; wa_b = 25; wd_b = 32'h77;
      clr_req = 1;
      tick();
      rst = 1; we_b = 0; clr_req = 0;
      rd_at(20, 25);
      chk("rst_mid_r20", rd[31:0], 32'h0);
      chk("rst_beats_wr", rd[63:32], 32'h0);
      chk("rst_mid_busy", {31'b0, clr_busy}, 32'h0);
      chk("rst_mid_done", {31'b0, clr_done}, 32'h0);
      for (int c = 0; c < 25; c++) begin
         tick();
         chk("rst_no_done", {31'b0, clr_done}, 32'h0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
